imu_filter: RTL

IMU_FILTER -- requirements
Module: imu_filter

---
 rtl/imu_pkg.sv | 28 ++
 rtl/imu_ema_step.sv | 38 +++
 rtl/imu_filter.sv | 115 +++++++++++
 3 files changed

// File: rtl/imu_pkg.sv
// Shared types and constants for the IMU EMA filter: FSM states, lane geometry
// and lane slicing helpers used by imu_filter and imu_ema_step.
package imu_pkg;

  localparam int LANES  = 6;
  localparam int LANE_W = 16;
  localparam int DATA_W = LANES * LANE_W;
  localparam int IDX_W  = 3;

  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

  // Lane 0 sits in the most significant bits of the sample word.
  localparam int LANE_LSB [LANES] = '{80, 64, 48, 32, 16, 0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } imu_state_e;

  typedef logic signed [LANE_W-1:0] lane_t;

  function automatic lane_t lane_of(input logic [DATA_W-1:0] word,
                                    input logic [IDX_W-1:0]  idx);
    lane_of = word[DATA_W-1 - int'(idx)*LANE_W -: LANE_W];
  endfunction

endpackage

// File: rtl/imu_ema_step.sv
// One-lane EMA step: y_new = y + ((x - y) >>> K), or y = x before priming.
// Optional output dead-band when IMU_FILTER_DEADBAND_EN is defined.
module imu_ema_step
  import imu_pkg::*;
#(
  parameter int K        = 2,
  parameter int DEADBAND = 16
) (
  input  lane_t x,
  input  lane_t y,
  input  logic  primed,
  output lane_t y_new,
  output lane_t y_out
);

`ifdef IMU_FILTER_DEADBAND_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic signed [LANE_W:0] diff;
  logic signed [LANE_W:0] step;
  logic        [LANE_W:0] mag;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    diff  = {x[LANE_W-1], x} - {y[LANE_W-1], y};
    step  = diff >>> K;
    y_new = primed ? lane_t'(y + step[LANE_W-1:0]) : x;

    // 17-bit magnitude so that -32768 does not wrap back to a negative value.
    mag   = y_new[LANE_W-1] ? (LANE_W+1)'(-{1'b1, y_new}) : {1'b0, y_new};
    y_out = y_new;
    if (DB_EN && (mag <= (LANE_W+1)'(DEADBAND))) y_out = '0;
  end

endmodule

// File: rtl/imu_filter.sv
// Six-lane exponential moving-average filter for IMU samples with one shared
// datapath stepped through the lanes. Optional dead-band: IMU_FILTER_DEADBAND_EN.
module imu_filter
  import imu_pkg::*;
#(
  parameter int K        = 2,
  parameter int DEADBAND = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] imu_data,
  output logic [DATA_W-1:0] filt_data,
  output logic              filt_valid,
  output logic              busy
);

  imu_state_e        state;
  imu_state_e        next_state;
  logic [IDX_W-1:0]  lane_idx;
  logic [DATA_W-1:0] prev_data;
  logic [DATA_W-1:0] snapshot;
  lane_t             y_state   [LANES];
  lane_t             out_stage [LANES-1];
  logic              primed;
  logic              pending;

  logic              new_sample;
  logic              start;
  lane_t             step_x;
  lane_t             step_y;
  lane_t             step_new;
  lane_t             step_out;
  logic [DATA_W-1:0] filt_next;

  assign new_sample = (imu_data != prev_data);
  assign start      = (state == ST_IDLE) && (new_sample || pending);
  assign step_x     = lane_of(snapshot, lane_idx);
  assign step_y     = y_state[lane_idx];

  imu_ema_step #(
    .K        (K),
    .DEADBAND (DEADBAND)
  ) u_step (
    .x      (step_x),
    .y      (step_y),
    .primed (primed),
    .y_new  (step_new),
    .y_out  (step_out)
  );

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    filt_valid = 1'b0;
    case (state)
      ST_IDLE: if (start) next_state = ST_CALC;
      ST_CALC: begin
        busy = 1'b1;
        if (lane_idx == LAST_LANE) next_state = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        filt_valid = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // The last lane bypasses the staging registers so the word is complete in DONE.
  always_comb begin
    filt_next = filt_data;
    for (int i = 0; i < LANES-1; i++) filt_next[LANE_LSB[i] +: LANE_W] = out_stage[i];
    filt_next[LANE_LSB[LANES-1] +: LANE_W] = step_out;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      lane_idx  <= '0;
      prev_data <= '0;
      snapshot  <= '0;
      filt_data <= '0;
      primed    <= 1'b0;
      pending   <= 1'b0;
      // NOTE: the lane arrays are small flop banks with a defined post-reset value, not RAMs, so they are reset here.
      for (int i = 0; i < LANES; i++)   y_state[i]   <= '0;
      for (int i = 0; i < LANES-1; i++) out_stage[i] <= '0;
    end else begin
      state     <= next_state;
      prev_data <= imu_data;

      if (start) begin
        snapshot <= imu_data;
        lane_idx <= '0;
        pending  <= 1'b0;
      end else if (busy && new_sample) begin
        pending <= 1'b1;
      end

      if (state == ST_CALC) begin
        y_state[lane_idx] <= step_new;
        lane_idx          <= lane_idx + 1'b1;
        if (lane_idx != LAST_LANE) begin
          out_stage[lane_idx] <= step_out;
        end else begin
          filt_data <= filt_next;
          primed    <= 1'b1;
        end
      end
    end
  end

endmodule
